// File: rtl/serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_seq
// Description : Bit-serial ALU sequencer, one bit per clock, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       aluOp,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carryOut
);

   localparam int                c_cnt_w = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);
   localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [2:0]         r_op;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_carry;
   logic [WIDTH-2:0]   r_shift;

   logic               w_accept;
   logic               w_last;
   logic               w_a;
   logic               w_bx;
   logic               w_sum;
   logic               w_cout;
   logic               w_ovf;
   logic               w_set;
   logic               w_add_class;
   logic               w_bit;
   logic [WIDTH-1:0]   w_final;
   logic [WIDTH-2:0]   w_shift_nxt;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == c_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = start ? S_RUN : S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign busy     = (r_state == S_RUN);
   assign done     = (r_state == S_DONE);
   assign w_accept = start && (r_state != S_RUN);
   assign w_last   = busy && (r_cnt == c_last);

   // ------------------------------------------------------------------------
   // Per-bit slice: operands are shifted right so bit 0 is always current
   // ------------------------------------------------------------------------
   assign w_a         = r_a[0];
   assign w_bx        = r_b[0] ^ r_op[2];
   assign w_sum       = w_a ^ w_bx ^ r_carry;
   assign w_cout      = (w_a & w_bx) | (r_carry & (w_a ^ w_bx));
   assign w_ovf       = r_carry ^ w_cout;
   assign w_set       = w_sum ^ w_ovf;
   assign w_add_class = r_op[1];

   // The set bit is only known after the MSB, so sel 11 shifts in zeros and
   // the bit is inserted at commit time.
   always_comb begin
      w_bit = 1'b0;
      case (r_op[1:0])
         2'b00:   w_bit = w_a & w_bx;
         2'b01:   w_bit = r_op[2] ? ~(w_a | r_b[0]) : (w_a | w_bx);
         2'b10:   w_bit = w_sum;
         default: w_bit = 1'b0;
      endcase
   end

   assign w_shift_nxt = (WIDTH-1)'({w_bit, r_shift} >> 1);
   assign w_final     = (r_op[1:0] == 2'b11) ? {{(WIDTH-1){1'b0}}, w_set}
                                             : {w_bit, r_shift};

   // ------------------------------------------------------------------------
   // Operand, carry and shift registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_shift <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_op    <= aluOp;
         r_cnt   <= '0;
         r_carry <= aluOp[2];
         r_shift <= '0;
      end else if (busy) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_cout;
         r_shift <= w_shift_nxt;
         if (!w_last) begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Result and flag commit, only on entry to DONE
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         carryOut <= 1'b0;
      end else if (w_last) begin
         result   <= w_final;
         zero     <= (w_final == '0);
         overflow <= w_add_class & w_ovf;
         carryOut <= w_add_class & w_cout;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_alu_seq
// Description : Self-checking bench for serial_alu_seq with reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_alu_seq;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          start;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    aluOp;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          zero;
   logic          overflow;
   logic          carryOut;

   int            pass_cnt  = 0;
   int            total_cnt = 0;
   logic [W-1:0]  exp_prev  = '0;

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .a        (a),
      .b        (b),
      .aluOp    (aluOp),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .zero     (zero),
      .overflow (overflow),
      .carryOut (carryOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Word-level reference: signed/unsigned arithmetic on whole operands.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2:0] op, output logic [W-1:0] r,
                                 output logic z, output logic v, output logic c);
      logic [W-1:0] bx;
      logic [W:0]   s;
      logic         ovf;
      logic         set;
      bx  = op[2] ? ~y : y;
      s   = {1'b0, x} + {1'b0, bx} + (W+1)'(op[2]);
      ovf = (x[W-1] == bx[W-1]) && (s[W-1] != x[W-1]);
      set = s[W-1] ^ ovf;
      case (op[1:0])
         2'b00:   r = x & bx;
         2'b01:   r = op[2] ? ~(x | y) : (x | y);
         2'b10:   r = s[W-1:0];
         default: r = {{(W-1){1'b0}}, set};
      endcase
      v = op[1] ? ovf : 1'b0;
      c = op[1] ? s[W] : 1'b0;
      z = (r == '0);
   endfunction

   // Issues one operation and waits for done; scrambles inputs while busy.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic [2:0] top, input int inject_at,
                        output int lat, output bit busy_ok, output bit hold_ok);
      @(negedge clk);
      a = ta; b = tbv; aluOp = top; start = 1'b1;
      lat = 0; busy_ok = 1'b1; hold_ok = 1'b1;
      @(posedge clk);
      while (lat < 100) begin
         @(negedge clk);
         start = 1'b0;
         if (done) break;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (result !== exp_prev) hold_ok = 1'b0;
         a = $urandom; b = $urandom; aluOp = 3'($urandom_range(0, 7));
         if (lat == inject_at) start = 1'b1;
         @(posedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; a = '0; b = '0; aluOp = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({busy, done, result, zero, overflow, carryOut} !== '0)
         $display("FAIL reset_state: busy=%b done=%b result=%h z=%b v=%b c=%b, want all 0",
                  busy, done, result, zero, overflow, carryOut);
      else pass_cnt++;
      reset = 1'b0;
      exp_prev = '0;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [10] = '{32'h7FFFFFFF, 32'h5, 32'hFFFFFFFF, 32'h80000000, 32'h1,
                                32'hFF00FF00, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                32'h7FFFFFFF};
      logic [W-1:0] tv [10] = '{32'h1, 32'h5, 32'h1, 32'h1, 32'hFFFFFFFF,
                                32'h0FF00FF0, 32'h0F0F0000, 32'h0F0F0000, 32'h0F0F0000,
                                32'h1};
      logic [2:0]   to [10] = '{3'b010, 3'b110, 3'b111, 3'b111, 3'b111,
                                3'b000, 3'b101, 3'b001, 3'b100, 3'b011};
      logic [W-1:0] er [10] = '{32'h80000000, 32'h0, 32'h1, 32'h1, 32'h0,
                                32'h0F000F00, 32'h00000F0F, 32'hFFFFF0F0, 32'hF0F0F0F0,
                                32'h0};
      logic [2:0]   ef [10] = '{3'b010, 3'b101, 3'b001, 3'b011, 3'b100,
                                3'b000, 3'b000, 3'b000, 3'b000, 3'b110};
      int lat; bit bok; bit hok;
      for (int i = 0; i < 10; i++) begin
         do_op(ta[i], tv[i], to[i], -1, lat, bok, hok);
         total_cnt++;
         if (lat != W) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, W);
         else pass_cnt++;
         total_cnt++;
         if (result !== er[i]) $display("FAIL dir%0d_result: got %h want %h", i, result, er[i]);
         else pass_cnt++;
         total_cnt++;
         if ({zero, overflow, carryOut} !== ef[i])
            $display("FAIL dir%0d_flags: got zvc=%b%b%b want %b", i, zero, overflow, carryOut, ef[i]);
         else pass_cnt++;
         total_cnt++;
         if (!bok || !hok) $display("FAIL dir%0d_busy_hold: busy_ok=%b hold_ok=%b want 1 1", i, bok, hok);
         else pass_cnt++;
         exp_prev = er[i];
         @(negedge clk);
         total_cnt++;
         if (done !== 1'b0 || result !== er[i])
            $display("FAIL dir%0d_done_pulse: done=%b result=%h want 0 %h", i, done, result, er[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x; logic [W-1:0] y; logic [2:0] op;
      logic [W-1:0] r; logic z; logic v; logic c;
      int lat; bit bok; bit hok;
      for (int i = 0; i < 40; i++) begin
         x  = $urandom; y = $urandom; op = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) x = (i % 2) ? 32'h80000000 : 32'h7FFFFFFF;
         if ($urandom_range(0, 3) == 0) y = (i % 3 == 0) ? 32'h0 : x;
         model(x, y, op, r, z, v, c);
         do_op(x, y, op, -1, lat, bok, hok);
         total_cnt++;
         if (lat != W || !bok || !hok)
            $display("FAIL rnd%0d_timing: lat=%0d busy_ok=%b hold_ok=%b want %0d 1 1", i, lat, bok, hok, W);
         else pass_cnt++;
         total_cnt++;
         if ({result, zero, overflow, carryOut} !== {r, z, v, c})
            $display("FAIL rnd%0d_op%b a=%h b=%h: got %h zvc=%b%b%b want %h zvc=%b%b%b",
                     i, op, x, y, result, zero, overflow, carryOut, r, z, v, c);
         else pass_cnt++;
         exp_prev = r;
      end
   endtask

   task automatic test_ignore_start();
      int lat; bit bok; bit hok;
      do_op(32'h7FFFFFFF, 32'h1, 3'b010, 10, lat, bok, hok);
      total_cnt++;
      if (lat != W || !bok) $display("FAIL ignore_start_timing: lat=%0d busy_ok=%b want %0d 1", lat, bok, W);
      else pass_cnt++;
      total_cnt++;
      if (result !== 32'h80000000 || overflow !== 1'b1)
         $display("FAIL ignore_start_result: got %h v=%b want 80000000 v=1", result, overflow);
      else pass_cnt++;
      exp_prev = 32'h80000000;
   endtask

   task automatic test_back_to_back();
      int lat; bit bok; bit hok; int n;
      do_op(32'h5, 32'h3, 3'b110, -1, lat, bok, hok);
      total_cnt++;
      if (lat != W || result !== 32'h2) $display("FAIL b2b_first: lat=%0d result=%h want %0d 00000002", lat, result, W);
      else pass_cnt++;
      exp_prev = 32'h2;
      a = 32'h00001234; b = 32'h00004321; aluOp = 3'b010; start = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
         start = 1'b0;
      end while (!done && n < 100);
      total_cnt++;
      if (n != W + 1) $display("FAIL b2b_spacing: got %0d cycles want %0d", n, W + 1);
      else pass_cnt++;
      total_cnt++;
      if (result !== 32'h00005555 || zero !== 1'b0)
         $display("FAIL b2b_second: got %h z=%b want 00005555 z=0", result, zero);
      else pass_cnt++;
      exp_prev = 32'h00005555;
   endtask

   task automatic test_reset_mid_run();
      int lat; bit bok; bit hok; int seen;
      @(negedge clk);
      a = 32'h12345678; b = 32'h11111111; aluOp = 3'b010; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      total_cnt++;
      if ({busy, done, result, zero, overflow, carryOut} !== '0)
         $display("FAIL reset_mid_run: busy=%b done=%b result=%h zvc=%b%b%b want all 0",
                  busy, done, result, zero, overflow, carryOut);
      else pass_cnt++;
      exp_prev = '0;
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      total_cnt++;
      if (seen != 0 || result !== '0) $display("FAIL reset_no_done: done_count=%0d result=%h want 0 0", seen, result);
      else pass_cnt++;
      do_op(32'h0000000F, 32'h00000003, 3'b111, -1, lat, bok, hok);
      total_cnt++;
      if (lat != W || result !== 32'h0 || zero !== 1'b1 || carryOut !== 1'b1)
         $display("FAIL reset_recover: lat=%0d result=%h z=%b c=%b want %0d 0 1 1", lat, result, zero, carryOut, W);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
